nn_search_controller: RTL and testbench

//   Sequences one nearest-neighbour search over a vertex table held in BRAM.

---
 rtl/nn_search_controller_if.sv | 22 ++
 rtl/nn_search_controller.sv | 149 ++++++++++++++
 tb/tb_nn_search_controller.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_search_controller_if.sv
// Vertex-table read bus between the search controller and its BRAM.
// Address and strobe go out; coordinates return READ_LAT cycles later.
interface nn_search_controller_if #(
  parameter int DIM    = 2,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0]    mem_addr_out;
  logic                 mem_rd_out;
  logic [DIM-1:0][31:0] mem_data_in;

  modport master (
    output mem_addr_out,
    output mem_rd_out,
    input  mem_data_in
  );

  modport slave (
    input  mem_addr_out,
    input  mem_rd_out,
    output mem_data_in
  );
endinterface

// File: rtl/nn_search_controller.sv
// Nearest-neighbour search sequencer: streams vertices from BRAM into
// one distance pipeline and keeps the minimum distance and its index.
module nn_search_controller #(
  parameter int DIM      = 2,
  parameter int N_VERTS  = 1024,
  parameter int ADDR_W   = $clog2(N_VERTS),
  parameter int READ_LAT = 2,
  parameter int PIPE_LAT = 24
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [ADDR_W:0]       num_verts_in,
  input  logic [DIM-1:0][31:0]  query_pos_in,
  nn_search_controller_if.master mem,
  output logic [DIM-1:0]        vtx_valid_out,
  output logic [DIM-1:0][31:0]  vtx_pos_out,
  output logic [DIM-1:0][31:0]  qry_pos_out,
  input  logic [31:0]           dist_sq_in,
  input  logic                  dist_valid_in,
  output logic                  ready_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  found_out,
  output logic [ADDR_W-1:0]     best_idx_out,
  output logic [31:0]           best_dist_out
);

  localparam int HOLD = READ_LAT + PIPE_LAT + 1;
  localparam int HW   = $clog2(HOLD + 1);
  localparam logic [31:0]   P_INF  = 32'h7F80_0000;
  localparam logic [ADDR_W:0] NV_MAX = (ADDR_W + 1)'(N_VERTS);

  typedef enum logic [2:0] {
    HOLDOFF,
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t               state;
  logic [HW-1:0]        hold_cnt;
  logic [ADDR_W:0]      nv;
  logic [ADDR_W:0]      nv_clamp;
  logic [ADDR_W:0]      issue_cnt;
  logic [ADDR_W:0]      ret_cnt;
  logic [ADDR_W:0]      ret_nxt;
  logic [READ_LAT-1:0]  vld_sr;
  logic [DIM-1:0][31:0] qry;
  logic                 rd;
  logic [ADDR_W-1:0]    addr;
  logic                 cmp_en;
  logic                 is_nan;
  logic                 better;

  assign nv_clamp = (num_verts_in > NV_MAX) ? NV_MAX : num_verts_in;
  assign cmp_en   = dist_valid_in && (state == ISSUE || state == DRAIN);
  assign is_nan   = (dist_sq_in[30:23] == 8'hFF) && (dist_sq_in[22:0] != '0);
  // Non-negative FP32 orders the same as its unsigned bit pattern
  assign better   = cmp_en && !is_nan && (dist_sq_in < best_dist_out);
  assign ret_nxt  = ret_cnt + (ADDR_W + 1)'(cmp_en);

  assign mem.mem_addr_out = addr;
  assign mem.mem_rd_out   = rd;
  assign vtx_valid_out    = {DIM{vld_sr[READ_LAT-1]}};
  assign vtx_pos_out      = mem.mem_data_in;
  assign qry_pos_out      = qry;
  assign ready_out        = (state == IDLE);
  assign busy_out         = (state == ISSUE) || (state == DRAIN) ||
                            (state == DONE);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state         <= HOLDOFF;
      hold_cnt      <= '0;
      nv            <= '0;
      issue_cnt     <= '0;
      ret_cnt       <= '0;
      vld_sr        <= '0;
      qry           <= '0;
      rd            <= 1'b0;
      addr          <= '0;
      done_out      <= 1'b0;
      found_out     <= 1'b0;
      best_idx_out  <= '0;
      best_dist_out <= P_INF;
    end else begin
      done_out <= 1'b0;
      vld_sr   <= (vld_sr << 1) | READ_LAT'(rd);
      if (cmp_en) begin
        ret_cnt <= ret_nxt;
        if (!is_nan) found_out <= 1'b1;
        if (better) begin
          best_dist_out <= dist_sq_in;
          best_idx_out  <= ret_cnt[ADDR_W-1:0];
        end
      end
      unique case (state)
        HOLDOFF: begin
          // Results still in the distance pipe at reset drain here
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HW'(HOLD - 1)) begin
            state  <= IDLE;
            vld_sr <= '0;
          end
        end
        IDLE: begin
          if (start_in) begin
            qry           <= query_pos_in;
            nv            <= nv_clamp;
            best_dist_out <= P_INF;
            best_idx_out  <= '0;
            found_out     <= 1'b0;
            ret_cnt       <= '0;
            if (nv_clamp == '0) begin
              state     <= DONE;
              issue_cnt <= '0;
            end else begin
              state     <= ISSUE;
              rd        <= 1'b1;
              addr      <= '0;
              issue_cnt <= (ADDR_W + 1)'(1);
            end
          end
        end
        ISSUE: begin
          if (issue_cnt == nv) begin
            rd    <= 1'b0;
            state <= DRAIN;
          end else begin
            addr      <= issue_cnt[ADDR_W-1:0];
            issue_cnt <= issue_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (ret_nxt == nv) state <= DONE;
        end
        DONE: begin
          done_out <= 1'b1;
          state    <= IDLE;
          vld_sr   <= '0;
        end
        default: state <= HOLDOFF;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_search_controller.sv
// Bench for nn_search_controller: BRAM model, FP32 distance model,
// a vector table of small searches and multi-cycle corner sequences.
module tb_nn_search_controller;

  localparam int DIM = 2;
  localparam int NV  = 1024;
  localparam int AW  = 10;
  localparam int RL  = 2;
  localparam int PL  = 24;
  localparam int LD  = 5;
  localparam logic [31:0] F0  = 32'h0000_0000;
  localparam logic [31:0] F1  = 32'h3F80_0000;
  localparam logic [31:0] F2  = 32'h4000_0000;
  localparam logic [31:0] F3  = 32'h4040_0000;
  localparam logic [31:0] F4  = 32'h4080_0000;
  localparam logic [31:0] F25 = 32'h41C8_0000;
  localparam logic [31:0] INF = 32'h7F80_0000;

  typedef struct {
    logic [AW:0]       nv;
    logic [63:0]       q;
    logic [3:0][63:0]  v;
    logic              nan;
    logic [AW-1:0]     e_idx;
    logic [31:0]       e_dist;
    logic              e_found;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 inject = 1'b0;
  logic                 nan_mode = 1'b0;
  logic [AW:0]          num_verts = '0;
  logic [DIM-1:0][31:0] query = '0;
  logic [DIM-1:0]       vtx_valid;
  logic [DIM-1:0][31:0] vtx_pos;
  logic [DIM-1:0][31:0] qry_pos;
  logic [31:0]          dist_sq;
  logic                 dist_valid;
  logic                 ready, busy, done, found;
  logic [AW-1:0]        best_idx;
  logic [31:0]          best_dist;

  nn_search_controller_if #(.DIM(DIM), .ADDR_W(AW)) mif ();

  nn_search_controller #(
    .DIM(DIM), .N_VERTS(NV), .ADDR_W(AW),
    .READ_LAT(RL), .PIPE_LAT(PL)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start),
    .num_verts_in  (num_verts),
    .query_pos_in  (query),
    .mem           (mif),
    .vtx_valid_out (vtx_valid),
    .vtx_pos_out   (vtx_pos),
    .qry_pos_out   (qry_pos),
    .dist_sq_in    (dist_sq),
    .dist_valid_in (dist_valid),
    .ready_out     (ready),
    .busy_out      (busy),
    .done_out      (done),
    .found_out     (found),
    .best_idx_out  (best_idx),
    .best_dist_out (best_dist)
  );

  function automatic real f2r(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:23] == 8'd0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] dist_f(
    input logic [DIM-1:0][31:0] v,
    input logic [DIM-1:0][31:0] q
  );
    real s;
    real t;
    s = 0.0;
    for (int k = 0; k < DIM; k++) begin
      t = f2r(v[k]) - f2r(q[k]);
      s = s + t * t;
    end
    return r2f(s);
  endfunction

  function automatic logic [63:0] pt(input logic [31:0] x, input logic [31:0] y);
    return {y, x};
  endfunction

  // BRAM with two-cycle read latency, plus read/address bookkeeping
  logic [DIM-1:0][31:0] mem_arr [NV];
  logic [DIM-1:0][31:0] rd_s1 = '0;
  int rd_total = 0;
  int rd_base = 0;
  int addr_err = 0;
  int done_total = 0;

  always @(posedge clk) begin
    rd_s1 <= mem_arr[mif.mem_addr_out];
    mif.mem_data_in <= rd_s1;
    if (mif.mem_rd_out) begin
      rd_total <= rd_total + 1;
      if (int'(mif.mem_addr_out) != rd_total - rd_base)
        addr_err <= addr_err + 1;
    end
    if (done) done_total <= done_total + 1;
  end

  // Distance pipeline with fixed latency LD
  logic [LD-1:0] dv_p = '0;
  logic [31:0]   dd_p [LD];

  always @(posedge clk) begin
    dv_p <= {dv_p[LD-2:0], vtx_valid[0]};
    dd_p[0] <= nan_mode ? 32'h7FC0_0000 : dist_f(vtx_pos, qry_pos);
    for (int i = 1; i < LD; i++) dd_p[i] <= dd_p[i-1];
  end

  assign dist_valid = dv_p[LD-1] | inject;
  assign dist_sq    = inject ? 32'd0 : dd_p[LD-1];

  int n_pass = 0;
  int n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_search(input logic [AW:0] nv, input logic [63:0] q,
                            output int lat, output int rds, output int dns);
    int base_d;
    rd_base = rd_total;
    base_d = done_total;
    start = 1'b1;
    num_verts = nv;
    query = q;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    repeat (12) @(negedge clk);
    rds = rd_total - rd_base;
    dns = done_total - base_d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vt [8];
  logic [3:0][63:0] va, vb;
  int lat, rds, dns, n, exp_lat, base_d;
  logic busy_seen;

  initial begin
    va = {pt(F1, F1), pt(F2, F0), pt(F1, F1), pt(F3, F4)};
    vb = {pt(F0, F2), pt(F2, F0), pt(F0, F2), pt(F2, F0)};
    vt[0] = '{nv: 11'd4, q: pt(F0, F0), v: va, nan: 1'b0,
              e_idx: 10'd1, e_dist: F2, e_found: 1'b1};
    vt[1] = '{nv: 11'd0, q: pt(F0, F0), v: va, nan: 1'b0,
              e_idx: 10'd0, e_dist: INF, e_found: 1'b0};
    vt[2] = '{nv: 11'd4, q: pt(F0, F0), v: va, nan: 1'b1,
              e_idx: 10'd0, e_dist: INF, e_found: 1'b0};
    vt[3] = '{nv: 11'd3, q: pt(F1, F1), v: va, nan: 1'b0,
              e_idx: 10'd1, e_dist: F0, e_found: 1'b1};
    vt[4] = '{nv: 11'd4, q: pt(F0, F0), v: vb, nan: 1'b0,
              e_idx: 10'd0, e_dist: F4, e_found: 1'b1};
    vt[5] = '{nv: 11'd4, q: pt(F2, F0), v: va, nan: 1'b0,
              e_idx: 10'd2, e_dist: F0, e_found: 1'b1};
    vt[6] = '{nv: 11'd1, q: pt(F0, F0), v: va, nan: 1'b0,
              e_idx: 10'd0, e_dist: F25, e_found: 1'b1};
    vt[7] = '{nv: 11'd4, q: pt(F3, F4), v: va, nan: 1'b0,
              e_idx: 10'd0, e_dist: F0, e_found: 1'b1};
    for (int k = 0; k < NV; k++) mem_arr[k] = '0;

    // Reset values, then holdoff length with start held high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 32'(ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst found", 32'(found), 32'd0);
    chk("rst best_idx", 32'(best_idx), 32'd0);
    chk("rst best_dist", best_dist, INF);
    chk("rst rd", 32'(mif.mem_rd_out), 32'd0);
    rst = 1'b1;
    start = 1'b1;
    num_verts = 11'd4;
    busy_seen = 1'b0;
    n = 0;
    while (!ready && n < 200) begin
      busy_seen = busy_seen | busy;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("holdoff cycles", n, RL + PL + 1);
    chk("holdoff busy", 32'(busy_seen), 32'd0);
    repeat (5) @(negedge clk);
    chk("holdoff reads", rd_total, 32'd0);

    // Table of small searches
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) mem_arr[k] = vt[i].v[k];
      nan_mode = vt[i].nan;
      run_search(vt[i].nv, vt[i].q, lat, rds, dns);
      exp_lat = (vt[i].nv == 0) ? 2 : int'(vt[i].nv) + RL + LD + 2;
      chk($sformatf("v%0d found", i), 32'(found), 32'(vt[i].e_found));
      chk($sformatf("v%0d best_idx", i), 32'(best_idx), 32'(vt[i].e_idx));
      chk($sformatf("v%0d best_dist", i), best_dist, vt[i].e_dist);
      chk($sformatf("v%0d reads", i), rds, 32'(vt[i].nv));
      chk($sformatf("v%0d done pulses", i), dns, 32'd1);
      chk($sformatf("v%0d latency", i), lat, exp_lat);
    end
    nan_mode = 1'b0;
    chk("addr seq small", addr_err, 32'd0);

    // Full-table scan, minimum at the last index
    for (int k = 0; k < NV; k++)
      mem_arr[k] = pt(r2f(real'(NV - k)), F0);
    run_search(11'd1024, pt(F0, F0), lat, rds, dns);
    chk("full reads", rds, 32'd1024);
    chk("full best_idx", 32'(best_idx), 32'd1023);
    chk("full best_dist", best_dist, F1);
    chk("full found", 32'(found), 32'd1);
    chk("full latency", lat, NV + RL + LD + 2);
    chk("full addr seq", addr_err, 32'd0);

    // Oversized count clamps to the table depth
    run_search(11'd1500, pt(F0, F0), lat, rds, dns);
    chk("clamp reads", rds, 32'd1024);
    chk("clamp best_idx", 32'(best_idx), 32'd1023);
    chk("clamp addr seq", addr_err, 32'd0);

    // Reset in the middle of ISSUE aborts without done
    rd_base = rd_total;
    base_d = done_total;
    start = 1'b1;
    num_verts = 11'd100;
    query = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid busy", 32'(busy), 32'd1);
    chk("mid found", 32'(found), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort rd", 32'(mif.mem_rd_out), 32'd0);
    chk("abort best_dist", best_dist, INF);
    chk("abort found", 32'(found), 32'd0);
    inject = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    inject = 1'b0;
    wait_ready(n);
    chk("abort ready", 32'(ready), 32'd1);
    inject = 1'b1;
    repeat (3) @(negedge clk);
    inject = 1'b0;
    repeat (2) @(negedge clk);
    chk("stale found", 32'(found), 32'd0);
    chk("stale best_dist", best_dist, INF);
    chk("abort no done", done_total - base_d, 32'd0);
    for (int k = 0; k < 4; k++) mem_arr[k] = va[k];
    run_search(11'd4, pt(F0, F0), lat, rds, dns);
    chk("post best_idx", 32'(best_idx), 32'd1);
    chk("post best_dist", best_dist, F2);
    chk("post found", 32'(found), 32'd1);
    chk("post reads", rds, 32'd4);
    chk("post dones", dns, 32'd1);

    // start held high: one search per return to IDLE
    rd_base = rd_total;
    base_d = done_total;
    start = 1'b1;
    num_verts = 11'd4;
    query = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    chk("held first done", 32'(done), 32'd1);
    chk("held first reads", rd_total - rd_base, 32'd4);
    @(negedge clk);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("held second done", 32'(done), 32'd1);
    repeat (20) @(negedge clk);
    chk("held reads", rd_total - rd_base, 32'd8);
    chk("held dones", done_total - base_d, 32'd2);
    chk("held best_idx", 32'(best_idx), 32'd1);
    chk("held addr seq", addr_err, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
